can_bit_stuffer_tx: RTL and testbench

- Transmit-side CAN bit stuffer; the counterpart of the receive-path destuffing/stuff-error checker.
- Takes unstuffed frame bits from the frame-builder FSM over a 1-bit valid/ready handshake and drives canTX once per bit time on the txPoint strobe.
- Inserts a complementary stuff bit after STUFF_LEN equal consecutive bits while stuffing is enabled (SOF..CRC).
- Monitors bus readback at samplePoint and flags bit errors.

---
 rtl/can_pkg.sv | 13 +
 rtl/can_bit_monitor.sv | 27 ++
 rtl/can_bit_stuffer_tx.sv | 123 ++++++++++++
 tb/tb_can_bit_stuffer_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared CAN bit-level constants for the transmit stuffer and the receive destuffer.
package can_pkg;

    localparam logic DOMINANT          = 1'b0;
    localparam logic RECESSIVE         = 1'b1;

    // Default run length of equal bits that forces a stuff bit.
    localparam int   STUFF_LEN_DEFAULT = 5;

    // Width of the equal-bit run counter (run lengths up to 7).
    localparam int   BIT_CNT_W         = 3;

endpackage

// File: rtl/can_bit_monitor.sv
// Bus readback monitor: compares the bus level against the driven level at the
// sample point and reports a mismatch as a one-cycle pulse.
module can_bit_monitor
    import can_pkg::*;
(
    input  logic clock,
    input  logic resetN,
    input  logic samplePoint,
    input  logic canRX,
    input  logic canTX,
    output logic bitError
);

    logic bit_error_reg;

    // Register the readback compare; canTX here is the value driven before this edge.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            bit_error_reg <= 1'b0;
        end else begin
            bit_error_reg <= samplePoint && (canRX != canTX);
        end
    end

    assign bitError = bit_error_reg;

endmodule

// File: rtl/can_bit_stuffer_tx.sv
// Transmit-side CAN bit stuffer: one-entry holding register fed by the frame
// builder, equal-bit run counter, stuff-bit insertion on txPoint, and bus
// readback checking through can_bit_monitor.
module can_bit_stuffer_tx
    import can_pkg::*;
#(
    parameter int   STUFF_LEN = STUFF_LEN_DEFAULT,
    parameter logic RECESSIVE = can_pkg::RECESSIVE
)(
    input  logic clock,
    input  logic resetN,
    input  logic txPoint,
    input  logic samplePoint,
    input  logic bsOnOff,
    input  logic dataIn,
    input  logic dataValid,
    output logic dataReady,
    input  logic canRX,
    output logic canTX,
    output logic stuffing,
    output logic bitError,
    output logic underrun
);

    localparam logic [BIT_CNT_W-1:0] STUFF_CNT = BIT_CNT_W'(STUFF_LEN);
    localparam logic [BIT_CNT_W-1:0] CNT_ONE   = BIT_CNT_W'(1);

    logic                 tx_reg,        tx_next;
    logic                 stuffing_reg,  stuffing_next;
    logic                 hold_full_reg, hold_full_next;
    logic                 hold_bit_reg,  hold_bit_next;
    logic [BIT_CNT_W-1:0] count_reg,     count_next;
    logic                 last_reg,      last_next;
    logic                 underrun_reg,  underrun_next;

    logic stuff_pending;
    logic accept;

    assign stuff_pending = (count_reg == STUFF_CNT);
    // Accept only into an empty holding register, so accept and consume never coincide.
    assign accept        = dataValid && !hold_full_reg;

    // Next-state: holding register handshake plus per-bit-time drive decision.
    always_comb begin
        tx_next        = tx_reg;
        stuffing_next  = stuffing_reg;
        hold_full_next = hold_full_reg;
        hold_bit_next  = hold_bit_reg;
        count_next     = count_reg;
        last_next      = last_reg;
        underrun_next  = 1'b0;

        if (accept) begin
            hold_full_next = 1'b1;
            hold_bit_next  = dataIn;
        end

        if (txPoint) begin
            if (stuff_pending) begin
                // Stuff bit goes out even if stuffing was just disabled after the last CRC bit.
                tx_next       = ~last_reg;
                stuffing_next = 1'b1;
                last_next     = ~last_reg;
                count_next    = bsOnOff ? CNT_ONE : '0;
            end else if (hold_full_reg) begin
                tx_next        = hold_bit_reg;
                stuffing_next  = 1'b0;
                hold_full_next = 1'b0;
                last_next      = hold_bit_reg;
                if (!bsOnOff) begin
                    count_next = '0;
                end else if ((hold_bit_reg == last_reg) && (count_reg != '0)) begin
                    count_next = count_reg + CNT_ONE;
                end else begin
                    count_next = CNT_ONE;
                end
            end else begin
                // Nothing to send: idle recessive and restart the run count.
                tx_next       = RECESSIVE;
                stuffing_next = 1'b0;
                count_next    = '0;
                last_next     = RECESSIVE;
                underrun_next = bsOnOff;
            end
        end
    end

    // State registers; reset drops any held bit and any pending stuff bit.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            tx_reg        <= RECESSIVE;
            stuffing_reg  <= 1'b0;
            hold_full_reg <= 1'b0;
            hold_bit_reg  <= RECESSIVE;
            count_reg     <= '0;
            last_reg      <= RECESSIVE;
            underrun_reg  <= 1'b0;
        end else begin
            tx_reg        <= tx_next;
            stuffing_reg  <= stuffing_next;
            hold_full_reg <= hold_full_next;
            hold_bit_reg  <= hold_bit_next;
            count_reg     <= count_next;
            last_reg      <= last_next;
            underrun_reg  <= underrun_next;
        end
    end

    assign canTX     = tx_reg;
    assign stuffing  = stuffing_reg;
    assign dataReady = ~hold_full_reg;
    assign underrun  = underrun_reg;

    can_bit_monitor u_monitor (
        .clock       (clock),
        .resetN      (resetN),
        .samplePoint (samplePoint),
        .canRX       (canRX),
        .canTX       (tx_reg),
        .bitError    (bitError)
    );

endmodule

// File: tb/tb_can_bit_stuffer_tx.sv
// Directed bench for can_bit_stuffer_tx: table of per-bit-time vectors plus
// hand-written sequences for reset, same-edge accept/underrun and readback.
module tb_can_bit_stuffer_tx;

    logic clock = 1'b0;
    logic resetN;
    logic txPoint;
    logic samplePoint;
    logic bsOnOff;
    logic dataIn;
    logic dataValid;
    logic dataReady;
    logic canRX;
    logic canTX;
    logic stuffing;
    logic bitError;
    logic underrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    can_bit_stuffer_tx #(.STUFF_LEN(5), .RECESSIVE(1'b1)) dut (
        .clock       (clock),
        .resetN      (resetN),
        .txPoint     (txPoint),
        .samplePoint (samplePoint),
        .bsOnOff     (bsOnOff),
        .dataIn      (dataIn),
        .dataValid   (dataValid),
        .dataReady   (dataReady),
        .canRX       (canRX),
        .canTX       (canTX),
        .stuffing    (stuffing),
        .bitError    (bitError),
        .underrun    (underrun)
    );

    // One bit time: bsOnOff, whether to offer a bit, its value, and the expected
    // dataReady after the offer cycle plus canTX/stuffing/underrun after txPoint.
    typedef struct packed {
        logic bs;
        logic feed;
        logic din;
        logic exp_ready;
        logic exp_tx;
        logic exp_stuff;
        logic exp_under;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic bs, input logic feed, input logic din,
                       input logic rdy, input logic tx, input logic st, input logic un);
        vec_t v;
        v.bs = bs; v.feed = feed; v.din = din;
        v.exp_ready = rdy; v.exp_tx = tx; v.exp_stuff = st; v.exp_under = un;
        vecs.push_back(v);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            bsOnOff   = vecs[i].bs;
            dataValid = vecs[i].feed;
            dataIn    = vecs[i].din;
            txPoint   = 1'b0;
            tick();
            check($sformatf("row%0d dataReady", i), dataReady, vecs[i].exp_ready);
            dataValid = 1'b0;
            txPoint   = 1'b1;
            tick();
            check($sformatf("row%0d canTX", i), canTX, vecs[i].exp_tx);
            check($sformatf("row%0d stuffing", i), stuffing, vecs[i].exp_stuff);
            check($sformatf("row%0d underrun", i), underrun, vecs[i].exp_under);
            $display("row %0d: bs=%b feed=%b din=%b -> canTX=%b stuffing=%b underrun=%b ready=%b",
                     i, vecs[i].bs, vecs[i].feed, vecs[i].din, canTX, stuffing, underrun, dataReady);
            txPoint = 1'b0;
            tick();
            check($sformatf("row%0d canTX hold", i), canTX, vecs[i].exp_tx);
            check($sformatf("row%0d stuffing hold", i), stuffing, vecs[i].exp_stuff);
            check($sformatf("row%0d underrun pulse", i), underrun, 1'b0);
        end
    endtask

    int g1, g2, g3, g4, g5, g6, g_end;

    initial begin
        // Five ones then a zero: stuff bit 0 after the fifth one.
        g1 = vecs.size();
        for (int k = 0; k < 5; k++) add(1, 1, 1, 0, 1, 0, 0);
        add(1, 1, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0);
        // Eight zeros: 0,0,0,0,0,1s,0,0,0 with dataReady low while the stuff bit is out.
        g2 = vecs.size();
        for (int k = 0; k < 5; k++) add(1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0);
        // End of CRC: stuff still emitted after bsOnOff drops, then six zeros pass unstuffed.
        g3 = vecs.size();
        for (int k = 0; k < 5; k++) add(1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 0);
        for (int k = 0; k < 6; k++) add(0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0);
        // Underrun, then the next run counts from 1.
        g4 = vecs.size();
        add(1, 0, 0, 1, 1, 0, 1);
        for (int k = 0; k < 5; k++) add(1, 1, 1, 0, 1, 0, 0);
        add(1, 1, 1, 0, 0, 1, 0);
        add(1, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0);
        // Build a run of four zeros before a mid-frame reset.
        g5 = vecs.size();
        for (int k = 0; k < 4; k++) add(1, 1, 0, 0, 0, 0, 0);
        // After reset: five zeros needed before the stuff bit.
        g6 = vecs.size();
        for (int k = 0; k < 5; k++) add(1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 1, 1, 0, 0);
        g_end = vecs.size();

        resetN      = 1'b0;
        txPoint     = 1'b0;
        samplePoint = 1'b0;
        bsOnOff     = 1'b0;
        dataIn      = 1'b0;
        dataValid   = 1'b0;
        canRX       = 1'b1;
        tick();
        tick();
        check("reset canTX", canTX, 1'b1);
        check("reset stuffing", stuffing, 1'b0);
        check("reset dataReady", dataReady, 1'b1);
        check("reset bitError", bitError, 1'b0);
        check("reset underrun", underrun, 1'b0);
        resetN = 1'b1;
        tick();

        run_rows(g1, g5);
        run_rows(g5, g6);

        // Hold a fifth zero with count at four, then reset asynchronously mid-cycle.
        bsOnOff   = 1'b1;
        dataValid = 1'b1;
        dataIn    = 1'b0;
        tick();
        dataValid = 1'b0;
        check("pre-reset dataReady", dataReady, 1'b0);
        check("pre-reset canTX", canTX, 1'b0);
        #2;
        resetN = 1'b0;
        #1;
        check("async reset canTX", canTX, 1'b1);
        check("async reset dataReady", dataReady, 1'b1);
        check("async reset stuffing", stuffing, 1'b0);
        $display("mid-frame reset: canTX=%b dataReady=%b stuffing=%b", canTX, dataReady, stuffing);
        tick();
        resetN = 1'b1;
        tick();
        run_rows(g6, g_end);

        // txPoint with empty hold and an accept on the same edge.
        bsOnOff   = 1'b1;
        txPoint   = 1'b1;
        dataValid = 1'b1;
        dataIn    = 1'b0;
        tick();
        check("same-edge underrun", underrun, 1'b1);
        check("same-edge canTX", canTX, 1'b1);
        check("same-edge dataReady", dataReady, 1'b0);
        $display("same-edge accept: canTX=%b underrun=%b ready=%b", canTX, underrun, dataReady);
        txPoint   = 1'b0;
        dataValid = 1'b0;
        tick();
        check("same-edge underrun end", underrun, 1'b0);
        check("same-edge canTX idle", canTX, 1'b1);
        txPoint = 1'b1;
        tick();
        check("deferred bit canTX", canTX, 1'b0);
        check("deferred bit underrun", underrun, 1'b0);
        check("deferred bit dataReady", dataReady, 1'b1);
        $display("deferred bit: canTX=%b underrun=%b", canTX, underrun);
        txPoint = 1'b0;
        bsOnOff = 1'b0;
        tick();

        // Readback: canTX is now 0.
        samplePoint = 1'b1;
        canRX       = 1'b1;
        tick();
        check("bitError on mismatch", bitError, 1'b1);
        $display("readback canRX=1 canTX=%b -> bitError=%b", canTX, bitError);
        samplePoint = 1'b0;
        tick();
        check("bitError one cycle", bitError, 1'b0);
        samplePoint = 1'b1;
        canRX       = 1'b0;
        tick();
        check("bitError on match", bitError, 1'b0);
        $display("readback canRX=0 canTX=%b -> bitError=%b", canTX, bitError);
        samplePoint = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
